// File: rtl/track_section_arbiter.sv
// Round-robin arbiter for a single-track section shared by trains A and B.
// Tracks occupancy from entry/exit sensors, enforces a clearance gap and latches faults.
module track_section_arbiter #(
  parameter int CLEAR_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic enter,
  input  logic exit,
  input  logic fault_clr,
  output logic green_a,
  output logic green_b,
  output logic occupied,
  output logic owner,
  output logic fault
);

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    OCCUPIED,
    CLEAR,
    FAULT
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST   = CNT_W'(CLEAR_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic             last_owner_q, last_owner_d;
  logic             green_a_q, green_a_d;
  logic             green_b_q, green_b_d;
  logic             occupied_q, occupied_d;
  logic             fault_q, fault_d;
  logic             owner_req;

  assign owner_req = owner_q ? req_b : req_a;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      green_a_q    <= 1'b0;
      green_b_q    <= 1'b0;
      occupied_q   <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      green_a_q    <= green_a_d;
      green_b_q    <= green_b_d;
      occupied_q   <= occupied_d;
      fault_q      <= fault_d;
    end
  end

  // The counter runs from grant through occupancy so the timeout covers the whole pass.
  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;

    case (state_q)
      IDLE: begin
        if (enter || exit) begin
          state_d = FAULT;
        end else if (req_a || req_b) begin
          state_d = GRANT;
          owner_d = (req_a && req_b) ? ~last_owner_q : req_b;
        end
      end

      GRANT: begin
        cnt_d = cnt_q + 1'b1;
        if (exit) begin
          state_d = FAULT;
        end else if (enter) begin
          state_d = OCCUPIED;
        end else if (!owner_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = FAULT;
        end
      end

      OCCUPIED: begin
        cnt_d = cnt_q + 1'b1;
        if (enter) begin
          state_d = FAULT;
        end else if (exit) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = FAULT;
        end
      end

      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (enter || exit) begin
          state_d = FAULT;
        end else if (cnt_q == CLEAR_LAST) begin
          state_d      = IDLE;
          last_owner_d = owner_q;
        end
      end

      FAULT: begin
        if (fault_clr && !enter && !exit) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    green_a_d  = (state_d == GRANT) && !owner_d;
    green_b_d  = (state_d == GRANT) && owner_d;
    // A fault freezes occupancy at whatever it was when the fault was raised.
    occupied_d = (state_d == OCCUPIED) || ((state_d == FAULT) && occupied_q);
    fault_d    = (state_d == FAULT);
  end

  assign green_a  = green_a_q;
  assign green_b  = green_b_q;
  assign occupied = occupied_q;
  assign owner    = owner_q;
  assign fault    = fault_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(green_a_q && green_b_q));
      assert (!((green_a_q || green_b_q) && occupied_q));
    end
  end

endmodule

// File: tb/tb_track_section_arbiter.sv
// Bench for track_section_arbiter: directed scenarios followed by random traffic,
// all cycles compared against a behavioural model of the section.
module tb_track_section_arbiter;

  localparam int CLEAR   = 4;
  localparam int TIMEOUT = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_a = 1'b0, req_b = 1'b0;
  logic enter = 1'b0, exit = 1'b0, fault_clr = 1'b0;
  logic green_a, green_b, occupied, owner, fault;

  int n_asserts = 0;
  int n_fails   = 0;

  // Model: who holds the green (-1 none), whether a train is inside, fault latch,
  // cycles since grant, and cycles of clearance still to serve.
  int m_green      = -1;
  bit m_occ        = 1'b0;
  bit m_fault      = 1'b0;
  bit m_owner      = 1'b0;
  bit m_last       = 1'b1;
  int m_age        = 0;
  int m_clear_left = 0;

  track_section_arbiter #(
    .CLEAR_CYCLES  (CLEAR),
    .TIMEOUT_CYCLES(TIMEOUT),
    .CNT_W         (10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_a    (req_a),
    .req_b    (req_b),
    .enter    (enter),
    .exit     (exit),
    .fault_clr(fault_clr),
    .green_a  (green_a),
    .green_b  (green_b),
    .occupied (occupied),
    .owner    (owner),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    bit own_req;
    if (rst) begin
      m_green = -1; m_occ = 0; m_fault = 0; m_owner = 0; m_last = 1;
      m_age = 0; m_clear_left = 0;
    end else if (m_fault) begin
      if (fault_clr && !enter && !exit) begin
        m_fault = 0;
        m_occ   = 0;
      end
    end else if (m_green != -1) begin
      own_req = (m_green == 0) ? req_a : req_b;
      if (exit) m_fault = 1;
      else if (enter) m_occ = 1;
      else if (!own_req) m_clear_left = CLEAR;
      else if (m_age == TIMEOUT - 1) m_fault = 1;
      if (exit || enter || !own_req || m_age == TIMEOUT - 1) m_green = -1;
      m_age++;
    end else if (m_occ) begin
      if (enter) m_fault = 1;
      else if (exit) begin
        m_occ = 0;
        m_clear_left = CLEAR;
      end else if (m_age == TIMEOUT - 1) m_fault = 1;
      m_age++;
    end else if (m_clear_left > 0) begin
      if (enter || exit) begin
        m_fault = 1;
        m_clear_left = 0;
      end else begin
        m_clear_left--;
        if (m_clear_left == 0) m_last = m_owner;
      end
    end else begin
      if (enter || exit) m_fault = 1;
      else if (req_a || req_b) begin
        m_owner = (req_a && req_b) ? !m_last : req_b;
        m_green = m_owner ? 1 : 0;
        m_age   = 0;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkModel();
    checkOutput("model_green_a", green_a, m_green == 0);
    checkOutput("model_green_b", green_b, m_green == 1);
    checkOutput("model_occupied", occupied, m_occ);
    checkOutput("model_owner", owner, m_owner);
    checkOutput("model_fault", fault, m_fault);
  endtask

  // One clock: pulses are held for exactly one cycle, then model and DUT are compared.
  task automatic applyStimulus(input logic en, input logic ex, input logic fc);
    enter     = en;
    exit      = ex;
    fault_clr = fc;
    @(posedge clk);
    model_step();
    #1;
    checkModel();
  endtask

  task automatic do_reset();
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic wait_green(input int max_cycles);
    for (int k = 0; k < max_cycles; k++) begin
      if (green_a || green_b) break;
      applyStimulus(0, 0, 0);
    end
    checkOutput("grant_wait", green_a | green_b, 1'b1);
  endtask

  initial begin
    int en_div, ex_div;
    logic en, ex, fc;

    // Basic pass for train A, then B waits out the clearance gap.
    do_reset();
    checkOutput("rst_green_a", green_a, 1'b0);
    checkOutput("rst_green_b", green_b, 1'b0);
    checkOutput("rst_occupied", occupied, 1'b0);
    checkOutput("rst_owner", owner, 1'b0);
    checkOutput("rst_fault", fault, 1'b0);
    req_a = 1'b1;
    applyStimulus(0, 0, 0);
    checkOutput("grant_a", green_a, 1'b1);
    checkOutput("grant_a_owner", owner, 1'b0);
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    checkOutput("enter_green_a", green_a, 1'b0);
    checkOutput("enter_occupied", occupied, 1'b1);
    req_a = 1'b0;
    applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 0);
    checkOutput("exit_occupied", occupied, 1'b0);
    req_b = 1'b1;
    for (int k = 0; k < CLEAR; k++) begin
      applyStimulus(0, 0, 0);
      checkOutput("clear_gap_green_b", green_b, 1'b0);
    end
    applyStimulus(0, 0, 0);
    checkOutput("after_clear_green_b", green_b, 1'b1);
    checkOutput("after_clear_owner", owner, 1'b1);

    // Both requests held: grants must alternate A, B, A.
    do_reset();
    req_a = 1'b1; req_b = 1'b1;
    for (int p = 0; p < 3; p++) begin
      wait_green(CLEAR + 4);
      checkOutput("alt_owner", green_b, p[0]);
      checkOutput("alt_exclusive", green_a & green_b, 1'b0);
      applyStimulus(1, 0, 0);
      applyStimulus(0, 1, 0);
    end

    // Grant with no entry: timeout fault exactly TIMEOUT cycles after green.
    do_reset();
    req_a = 1'b1;
    applyStimulus(0, 0, 0);
    checkOutput("to_grant", green_a, 1'b1);
    for (int k = 0; k < TIMEOUT - 1; k++) applyStimulus(0, 0, 0);
    checkOutput("to_not_yet", fault, 1'b0);
    applyStimulus(0, 0, 0);
    checkOutput("to_fault", fault, 1'b1);
    checkOutput("to_green_a", green_a, 1'b0);
    req_a = 1'b0;
    applyStimulus(1, 0, 1);
    checkOutput("clr_blocked_by_sensor", fault, 1'b1);
    applyStimulus(0, 0, 1);
    checkOutput("clr_fault", fault, 1'b0);

    // Second train entering an occupied section, then movement while idle.
    do_reset();
    req_a = 1'b1;
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    req_a = 1'b0;
    applyStimulus(1, 0, 0);
    checkOutput("double_enter_fault", fault, 1'b1);
    checkOutput("double_enter_occupied", occupied, 1'b1);
    applyStimulus(0, 0, 1);
    checkOutput("clr_occupied", occupied, 1'b0);
    applyStimulus(1, 0, 0);
    checkOutput("idle_enter_fault", fault, 1'b1);
    checkOutput("idle_enter_occupied", occupied, 1'b0);
    applyStimulus(0, 0, 1);

    // B withdraws before entering; A must wait the full gap.
    do_reset();
    req_b = 1'b1;
    applyStimulus(0, 0, 0);
    checkOutput("wd_grant_b", green_b, 1'b1);
    req_b = 1'b0; req_a = 1'b1;
    applyStimulus(0, 0, 0);
    checkOutput("wd_drop_green_b", green_b, 1'b0);
    for (int k = 0; k < CLEAR; k++) begin
      applyStimulus(0, 0, 0);
      checkOutput("wd_gap_green_a", green_a, 1'b0);
    end
    applyStimulus(0, 0, 0);
    checkOutput("wd_grant_a", green_a, 1'b1);
    checkOutput("wd_owner", owner, 1'b0);

    // Reset while occupied, then a fresh grant to B.
    do_reset();
    req_b = 1'b1;
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    req_b = 1'b0;
    rst = 1'b1;
    applyStimulus(0, 0, 0);
    checkOutput("mid_rst_occupied", occupied, 1'b0);
    checkOutput("mid_rst_owner", owner, 1'b0);
    checkOutput("mid_rst_green_b", green_b, 1'b0);
    rst = 1'b0;
    req_b = 1'b1;
    applyStimulus(0, 0, 0);
    checkOutput("post_rst_grant_b", green_b, 1'b1);
    req_b = 1'b0;

    // Random traffic with occasional sensor glitches, operator clears and resets.
    en_div = 4; ex_div = 4;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) begin
        en_div = $urandom_range(2, 30);
        ex_div = $urandom_range(2, 30);
      end
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 11) == 0) req_a = ~req_a;
      if ($urandom_range(0, 11) == 0) req_b = ~req_b;
      en = ((m_green != -1) && ($urandom_range(1, en_div) == 1)) || ($urandom_range(0, 79) == 0);
      ex = (m_occ && !m_fault && ($urandom_range(1, ex_div) == 1)) || ($urandom_range(0, 89) == 0);
      fc = ($urandom_range(0, 5) == 0);
      applyStimulus(en, ex, fc);
      checkOutput("rand_exclusive", (green_a | green_b) & occupied, 1'b0);
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/track_section_arbiter.md
Name: track_section_arbiter

Overview:
Arbiter for one shared single-track section used by two trains, A and B. It grants the section to one requester at a time with round-robin fairness. It tracks occupancy from the section's entry and exit sensors, enforces a clearance gap between trains and latches a fault on any sensor sequence violation or occupancy timeout. Its outputs drive the green/red section signals feeding each train's controller FSM.

Parameters:
CLEAR_CYCLES, 4, cycles the section stays blocked after exit before the next grant (>=1)
TIMEOUT_CYCLES, 1000, max cycles from grant to exit before fault (< 2^CNT_W)
CNT_W, 10, width of the shared clearance/timeout counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req_a  in  1  train A requests the section (level, held until served)
req_b  in  1  train B requests the section
enter  in  1  section entry sensor (1-cycle pulse per train)
exit  in  1  section exit sensor (1-cycle pulse per train)
fault_clr  in  1  operator clears a latched fault
green_a  out  1  proceed signal to train A
green_b  out  1  proceed signal to train B
occupied  out  1  section physically occupied
owner  out  1  current/last grantee: 0=A, 1=B
fault  out  1  latched fault indicator

Behaviour:
- Single clock; reset is synchronous and active-high. All outputs registered.
- Reset: state IDLE; green_a=0, green_b=0, occupied=0, owner=0, fault=0, counter=0, last_owner=1 (A wins first tie). Reset mid-operation aborts any grant and drops greens on the next edge.
- States: IDLE, GRANT, OCCUPIED, CLEAR, FAULT.
- IDLE:
  - enter or exit high -> FAULT (unauthorised movement).
  - else only req_a -> GRANT, owner=0; only req_b -> GRANT, owner=1.
  - both -> GRANT, owner=~last_owner.
  - Latency: request sampled at edge N, green of owner high from edge N+1. Counter cleared on entry to GRANT.
- GRANT: green of owner=1, other green=0. Counter increments each cycle. Priority order:
  - exit -> FAULT.
  - enter -> OCCUPIED; green drops at same edge.
  - owner's req low -> CLEAR (grant withdrawn, no movement).
  - counter == TIMEOUT_CYCLES-1 -> FAULT.
- OCCUPIED: occupied=1, both greens 0, counter keeps incrementing (not cleared). Priority order:
  - enter (with or without exit) -> FAULT (second train).
  - exit -> CLEAR.
  - counter == TIMEOUT_CYCLES-1 -> FAULT.
- CLEAR: occupied=0, greens 0. Counter cleared on entry, then counts up.
  - enter or exit -> FAULT.
  - counter == CLEAR_CYCLES-1 -> IDLE, last_owner<=owner.
  - The section is unavailable for exactly CLEAR_CYCLES cycles.
- FAULT: fault=1, greens 0, occupied holds its value at fault entry.
  - Exit only when fault_clr=1 and enter=0 and exit=0 -> IDLE; fault and occupied cleared, last_owner unchanged.
  - fault_clr outside FAULT is ignored.
- Requests arriving during GRANT/OCCUPIED/CLEAR are not queued. They are sampled only in IDLE, so levels must be held.
- Counter is CNT_W bits and never wraps in legal operation (parameter constraints above).
- At most one green is ever high; green and occupied are never high together.

Test Plan:
- Reset then req_a=1 at cycle 2 -> green_a=1 at cycle 3, owner=0; enter at 5 -> green_a=0, occupied=1 at 6; exit at 8 -> occupied=0 at 9; IDLE at cycle 13 (CLEAR_CYCLES=4).
- req_a=req_b=1 held continuously through three full passes -> grants alternate A, B, A; green_b never high while green_a is high.
- TIMEOUT_CYCLES=20, grant A, never pulse enter -> fault=1 20 cycles after green_a rose, greens 0; fault_clr=1 with sensors low -> IDLE next cycle, fault=0.
- OCCUPIED then enter pulsed again -> fault=1 next cycle, occupied stays 1; enter pulsed in IDLE -> fault=1.
- Grant B, drop req_b before enter -> green_b=0 next cycle, CLEAR for 4 cycles, then req_a granted with owner=0.
- rst asserted during OCCUPIED -> next cycle all outputs 0, owner=0; req_b alone -> green_b one cycle later.
